conway_frame_capture: RTL
=========================

// Module: conway_frame_capture
// PURPOSE
//   Downstream consumer of the 8x8 serial Conway engine's data_out stream.
//   - Deserialises each generation into a held board image with a registered row read port.
//   - Per generation: live-cell count, generation counter, extinct flag and still-life (stable) flag.
//   - Feeds the display / host-readback logic.
// PARAMETERS
//   ROWS   8   board rows
//   COLS   8   board columns; CELLS = ROWS*COLS
//   GEN_W  16  generation counter width
// PORTS
//   clk          in   1                 single clock, all logic on rising edge
//   rst_n        in   1                 synchronous, active-low reset
//   bit_in       in   1                 serial cell value from engine data_out (1 = live)
//   bit_valid    in   1                 bit_in qualifier, one cell per valid cycle
//   frame_start  in   1                 with bit_valid: this bit is cell 0 of a new generation
//   row_sel      in   $clog2(ROWS)      row to read
//   clear_err    in   1                 clears short_frame
//   row_data     out  COLS              registered row read, bit c = column c
//   frame_done   out  1                 1-cycle pulse: new generation committed
//   pop_count    out  $clog2(CELLS+1)   live cells in committed board
//   gen_count    out  GEN_W             committed generations since reset, wraps
//   extinct      out  1                 committed board all dead
//   stable       out  1                 committed board equals the previous one
//   short_frame  out  1                 sticky: frame restarted before completion
//   osc2         out  1                 period-2 oscillator detected (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): all outputs, board, shift reg, counters 0; FSM to IDLE; partial frame discarded.
//   - Cell order: serial index i -> row i/COLS, column i%COLS; index 0 is row 0, column 0.
//   - FSM IDLE:
//       bit_valid & frame_start -> SHIFT, bit captured as index 0.
//       bit_valid without frame_start -> ignored.
//   - FSM SHIFT: each bit_valid captures the next index; cycles without bit_valid hold state.
//       Capturing index CELLS-1 -> commit and return to IDLE.
//       A frame_start & bit_valid at index != 0 -> set short_frame, discard partial data,
//       restart with this bit as index 0 (stay SHIFT). Committed board untouched.
//   - Running live count: accumulated while shifting; its width holds CELLS without overflow.
//   - Commit happens on the edge that captures the final bit. From the next cycle:
//       board_q = new image; pop_count = running count incl. final bit;
//       gen_count += 1 (mod 2^GEN_W); frame_done = 1 for exactly one cycle;
//       extinct = (pop_count == 0);
//       stable = (new == previous board_q) AND a previous frame exists.
//   - stable is 0 for the first commit after reset, whose previous image is the reset zeros.
//   - Status outputs hold until the next commit or reset.
//   - frame_start on the final-bit cycle with index != 0 is treated as a restart, not a commit.
//   - short_frame is sticky until clear_err=1; if a set and clear_err coincide, set wins.
//   - row_data <= board_q row row_sel every cycle (1-cycle latency).
//       On a commit cycle it returns the pre-commit row; new data appears one cycle later.
//   - row_sel >= ROWS -> row_data = 0.
// CONFIGURATION
//   CONWAY_OSC2_DETECT_EN defined:
//     - Holds an extra image two generations back (board_q2).
//     - osc2 = (new == board_q2) & ~stable & at least two prior commits; updates on commit.
//   Not defined:
//     - No board_q2 storage; osc2 tied to 0.
// TESTING
//   1. Reset, then 64 valid bits all 1 with frame_start on first.
//      -> frame_done one cycle after last bit; pop_count=64, gen_count=1, extinct=0, stable=0.
//   2. Blinker (row3, cols 2-4) sent twice.
//      -> second commit: stable=1, pop_count=3, gen_count=2.
//      -> row_sel=3 gives row_data=8'h1C one cycle later.
//   3. 30 bits, then frame_start with a fresh 64-bit all-zero frame.
//      -> short_frame=1, extinct=1, gen_count=1.
//      -> clear_err pulse -> short_frame=0.
//   4. Random bit_valid gaps (about 50%) during one frame.
//      -> same board and pop_count as the gapless run; single frame_done pulse.
//   5. rst_n low at bit 40, then a full frame.
//      -> all outputs 0 during reset; next commit gen_count=1, stable=0.
//   6. With CONWAY_OSC2_DETECT_EN: blinker horizontal, vertical, horizontal.
//      -> third commit osc2=1, stable=0; without the macro osc2 stays 0.

Source files
------------

// File: rtl/conway_frame_capture.sv
// Captures the serial 8x8 Conway stream into a held board image and per-generation status.
// Optional period-2 oscillator detection: define CONWAY_OSC2_DETECT_EN.
module conway_frame_capture #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int GEN_W = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   input  logic                                bit_in_i,
   input  logic                                bit_valid_i,
   input  logic                                frame_start_i,
   input  logic [$clog2(ROWS)-1:0]             row_sel_i,
   input  logic                                clear_err_i,
   output logic [COLS-1:0]                     row_data_o,
   output logic                                frame_done_o,
   output logic [$clog2(ROWS*COLS+1)-1:0]      pop_count_o,
   output logic [GEN_W-1:0]                    gen_count_o,
   output logic                                extinct_o,
   output logic                                stable_o,
   output logic                                short_frame_o,
   output logic                                osc2_o
);
   localparam int CELLS = ROWS * COLS;
   localparam int IW    = $clog2(CELLS);
   localparam int PCW   = $clog2(CELLS + 1);
   localparam int RSW   = $clog2(ROWS);
   localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
   localparam logic [RSW:0]  ROWS_L   = (RSW + 1)'(ROWS);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CELLS-1:0]  img_q, img_d;
   logic [PCW-1:0]    cnt_q, cnt_d;
   logic [CELLS-1:0]  board_q, board_d;
   logic [PCW-1:0]    pop_q, pop_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic              extinct_q, extinct_d;
   logic              stable_q, stable_d;
   logic              short_q, short_d;
   logic              done_q, done_d;
   logic              prev_q, prev_d;
   logic [COLS-1:0]   row_q, row_d;
   logic [CELLS-1:0]  new_img;
   logic              commit;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      img_d     = img_q;
      cnt_d     = cnt_q;
      board_d   = board_q;
      pop_d     = pop_q;
      gen_d     = gen_q;
      extinct_d = extinct_q;
      stable_d  = stable_q;
      prev_d    = prev_q;
      done_d    = 1'b0;
      short_d   = short_q & ~clear_err_i;
      commit    = 1'b0;
      new_img   = img_q;
      new_img[idx_q] = bit_in_i;

      case (state_q)
         IDLE: begin
            if (bit_valid_i && frame_start_i) begin
               state_d  = SHIFT;
               img_d    = '0;
               img_d[0] = bit_in_i;
               idx_d    = IW'(1);
               cnt_d    = PCW'(bit_in_i);
            end
         end
         SHIFT: begin
            if (bit_valid_i) begin
               if (frame_start_i) begin
                  // Any frame_start inside SHIFT is at index != 0: restart, board untouched.
                  short_d  = 1'b1;
                  img_d    = '0;
                  img_d[0] = bit_in_i;
                  idx_d    = IW'(1);
                  cnt_d    = PCW'(bit_in_i);
               end else if (idx_q == LAST_IDX) begin
                  commit  = 1'b1;
                  state_d = IDLE;
                  idx_d   = '0;
                  img_d   = '0;
                  cnt_d   = '0;
               end else begin
                  img_d = new_img;
                  idx_d = idx_q + IW'(1);
                  cnt_d = cnt_q + PCW'(bit_in_i);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (commit) begin
         board_d   = new_img;
         pop_d     = cnt_q + PCW'(bit_in_i);
         gen_d     = gen_q + GEN_W'(1);
         done_d    = 1'b1;
         extinct_d = (pop_d == '0);
         stable_d  = prev_q && (new_img == board_q);
         prev_d    = 1'b1;
      end
   end

   // Read port samples the pre-commit board, so new data shows one cycle after frame_done.
   always_comb begin
      row_d = '0;
      if ({1'b0, row_sel_i} < ROWS_L) begin
         for (int c = 0; c < COLS; c++) begin
            row_d[c] = board_q[int'(row_sel_i) * COLS + c];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         img_q     <= '0;
         cnt_q     <= '0;
         board_q   <= '0;
         pop_q     <= '0;
         gen_q     <= '0;
         extinct_q <= 1'b0;
         stable_q  <= 1'b0;
         short_q   <= 1'b0;
         done_q    <= 1'b0;
         prev_q    <= 1'b0;
         row_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         img_q     <= img_d;
         cnt_q     <= cnt_d;
         board_q   <= board_d;
         pop_q     <= pop_d;
         gen_q     <= gen_d;
         extinct_q <= extinct_d;
         stable_q  <= stable_d;
         short_q   <= short_d;
         done_q    <= done_d;
         prev_q    <= prev_d;
         row_q     <= row_d;
      end
   end

`ifdef CONWAY_OSC2_DETECT_EN
   logic [CELLS-1:0] board2_q, board2_d;
   logic             prev2_q, prev2_d;
   logic             osc2_q, osc2_d;

   always_comb begin
      board2_d = board2_q;
      prev2_d  = prev2_q;
      osc2_d   = osc2_q;
      if (commit) begin
         board2_d = board_q;
         prev2_d  = prev_q;
         osc2_d   = prev2_q && (new_img == board2_q) && !stable_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         board2_q <= '0;
         prev2_q  <= 1'b0;
         osc2_q   <= 1'b0;
      end else begin
         board2_q <= board2_d;
         prev2_q  <= prev2_d;
         osc2_q   <= osc2_d;
      end
   end

   assign osc2_o = osc2_q;
`else
   assign osc2_o = 1'b0;
`endif

   assign row_data_o    = row_q;
   assign frame_done_o  = done_q;
   assign pop_count_o   = pop_q;
   assign gen_count_o   = gen_q;
   assign extinct_o     = extinct_q;
   assign stable_o      = stable_q;
   assign short_frame_o = short_q;
endmodule
